ram_master: RTL and testbench

RAM_MASTER -- requirements
Module: ram_master

---
 rtl/ram_master_pkg.sv | 6 +
 rtl/ram_master_arb.sv | 13 +
 rtl/ram_master.sv | 128 ++++++++++++
 tb/tb_ram_master.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_master_pkg.sv
// ram_master_pkg: shared state encoding and default widths for the RAM master.
package ram_master_pkg;
  localparam int AW_DEF = 14;
  localparam int DW_DEF = 8;
  typedef enum logic [1:0] {IDLE, RD1, RD2, WR} state_e;
endpackage

// File: rtl/ram_master_arb.sv
// ram_master_arb: two-port fairness arbiter; on conflict the port not granted last wins.
module ram_master_arb (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt0,
  output logic gnt1
);
  always_comb begin
    gnt0 = req0 & (~req1 | last_grant);
    gnt1 = req1 & (~req0 | ~last_grant);
  end
endmodule

// File: rtl/ram_master.sv
// ram_master: arbitrates two clients onto a synchronous single-port RAM with registered strobes.
module ram_master
  import ram_master_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          rvalid,
  output logic          rport,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          mem_ce_n,
  output logic          mem_oe_n,
  output logic          mem_we_n
);
  state_e        state_q, state_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          rvalid_q, rvalid_d, rport_q, rport_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [AW-1:0] mem_a_q, mem_a_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic          ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic          port_q, port_d, last_q, last_d;
  logic          r0, r1, gnt0, gnt1;

  // A request still visible during its own ack cycle is the one just accepted.
  assign r0 = req0 & ~ack0_q;
  assign r1 = req1 & ~ack1_q;

  ram_master_arb u_arb (
    .req0      (r0),
    .req1      (r1),
    .last_grant(last_q),
    .gnt0      (gnt0),
    .gnt1      (gnt1)
  );

  always_comb begin
    state_d   = state_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rvalid_d  = 1'b0;
    rport_d   = rport_q;
    rdata_d   = rdata_q;
    mem_a_d   = mem_a_q;
    mem_din_d = mem_din_q;
    port_d    = port_q;
    last_d    = last_q;
    if (state_q == RD2) begin
      rdata_d  = mem_dout;
      rvalid_d = 1'b1;
      rport_d  = port_q;
    end
    if (state_q == RD1) begin
      state_d = RD2;
    end else if (gnt0 | gnt1) begin
      state_d   = (gnt1 ? we1 : we0) ? WR : RD1;
      mem_a_d   = gnt1 ? addr1 : addr0;
      mem_din_d = gnt1 ? wdata1 : wdata0;
      ack0_d    = gnt0;
      ack1_d    = gnt1;
      port_d    = gnt1;
      last_d    = gnt1;
    end else begin
      state_d = IDLE;
    end
    ce_n_d = state_d == IDLE;
    oe_n_d = !(state_d == RD1 || state_d == RD2);
    we_n_d = state_d != WR;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rvalid_q  <= 1'b0;
      rport_q   <= 1'b0;
      rdata_q   <= '0;
      mem_a_q   <= '0;
      mem_din_q <= '0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      port_q    <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      rvalid_q  <= rvalid_d;
      rport_q   <= rport_d;
      rdata_q   <= rdata_d;
      mem_a_q   <= mem_a_d;
      mem_din_q <= mem_din_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      port_q    <= port_d;
      last_q    <= last_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rvalid   = rvalid_q;
  assign rport    = rport_q;
  assign rdata    = rdata_q;
  assign mem_a    = mem_a_q;
  assign mem_din  = mem_din_q;
  assign mem_ce_n = ce_n_q;
  assign mem_oe_n = oe_n_q;
  assign mem_we_n = we_n_q;
endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master: drives both clients against a behavioural synchronous RAM and a reference memory image.
module tb_ram_master;
  localparam int AW = 14;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, rvalid, rport;
  logic [DW-1:0] rdata, mem_din, mem_dout;
  logic [AW-1:0] mem_a;
  logic          mem_ce_n, mem_oe_n, mem_we_n;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] dout_r;
  logic          load = 1'b0;

  always #5 clk = ~clk;

  ram_master #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rvalid(rvalid), .rport(rport), .rdata(rdata),
    .mem_a(mem_a), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n)
  );

  // Synchronous RAM: writes and read-data registration happen on the edge ending a strobed cycle.
  always @(posedge clk) begin
    if (load) mem <= ref_mem;
    else if (!mem_ce_n && !mem_we_n) mem[mem_a] <= mem_din;
    if (!mem_ce_n && !mem_oe_n) dout_r <= mem[mem_a];
  end
  assign mem_dout = (!mem_ce_n && !mem_oe_n) ? dout_r : 'z;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic sync_mem();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic pulse_reset();
    req0 = 1'b0;
    req1 = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic access(input bit p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got = 1'b0;
    if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    else begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      got = p ? ack1 : ack0;
    end
    if (p) req1 = 1'b0; else req0 = 1'b0;
    checks++;
    if (!got || (p ? ack0 : ack1)) begin
      failures++;
      $display("FAIL access_ack port%0d: ack0=%b ack1=%b, required own ack within 10 cycles", p, ack0, ack1);
      return;
    end
    checks++;
    if (mem_a !== a || mem_ce_n !== 1'b0 || mem_we_n !== !w || mem_oe_n !== w || (w && mem_din !== d)) begin
      failures++;
      $display("FAIL access_strobes port%0d w=%0d: a=%h din=%h ce/oe/we=%b%b%b, required a=%h din=%h", p, w,
               mem_a, mem_din, mem_ce_n, mem_oe_n, mem_we_n, a, d);
    end
    if (w) begin
      ref_mem[a] = d;
      return;
    end
    tick();
    tick();
    checks++;
    if (rvalid !== 1'b1 || rport !== p || rdata !== ref_mem[a]) begin
      failures++;
      $display("FAIL access_read port%0d a=%h: rvalid=%b rport=%b rdata=%h, required 1 %0d %h", p, a,
               rvalid, rport, rdata, p, ref_mem[a]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 1'($urandom); req1 = 1'($urandom); we0 = 1'($urandom); we1 = 1'($urandom);
    addr0 = AW'($urandom); addr1 = AW'($urandom); wdata0 = DW'($urandom); wdata1 = DW'($urandom);
    repeat (3) tick();
    checks++;
    if ({mem_ce_n, mem_oe_n, mem_we_n} !== 3'b111 || mem_a !== '0 || mem_din !== '0) begin
      failures++;
      $display("FAIL reset_mem: ce/oe/we=%b%b%b a=%h din=%h, required 111 0 0", mem_ce_n, mem_oe_n, mem_we_n, mem_a, mem_din);
    end
    checks++;
    if ({ack0, ack1, rvalid, rport} !== 4'b0000 || rdata !== '0) begin
      failures++;
      $display("FAIL reset_client: ack0=%b ack1=%b rvalid=%b rport=%b rdata=%h, required all 0", ack0, ack1, rvalid, rport, rdata);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (mem_ce_n !== 1'b1 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: ce_n=%b ack0=%b ack1=%b, required 1 0 0", mem_ce_n, ack0, ack1);
    end
  endtask

  task automatic test_read_latency();
    ref_mem[14'h0123] = 8'hA5;
    sync_mem();
    req1 = 1'b1; we1 = 1'b0; addr1 = 14'h0123;
    tick();
    checks++;
    if (ack1 !== 1'b1 || ack0 !== 1'b0 || mem_ce_n !== 1'b0 || mem_oe_n !== 1'b0 || mem_a !== 14'h0123 || rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rd_cycle1: ack1=%b ce_n=%b oe_n=%b a=%h rvalid=%b, required 1 0 0 0123 0", ack1, mem_ce_n, mem_oe_n, mem_a, rvalid);
    end
    req1 = 1'b0;
    tick();
    checks++;
    if (ack1 !== 1'b0 || mem_ce_n !== 1'b0 || mem_oe_n !== 1'b0 || rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rd_cycle2: ack1=%b ce_n=%b oe_n=%b rvalid=%b, required 0 0 0 0", ack1, mem_ce_n, mem_oe_n, rvalid);
    end
    tick();
    checks++;
    if (rvalid !== 1'b1 || rport !== 1'b1 || rdata !== 8'hA5 || mem_ce_n !== 1'b1) begin
      failures++;
      $display("FAIL rd_cycle3: rvalid=%b rport=%b rdata=%h ce_n=%b, required 1 1 a5 1", rvalid, rport, rdata, mem_ce_n);
    end
    tick();
    checks++;
    if (rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rd_cycle4: rvalid=%b, required 0", rvalid);
    end
  endtask

  task automatic test_write_then_read();
    req0 = 1'b1; we0 = 1'b1; addr0 = 14'h3FFF; wdata0 = 8'h5A;
    tick();
    checks++;
    if (ack0 !== 1'b1 || mem_we_n !== 1'b0 || mem_ce_n !== 1'b0 || mem_oe_n !== 1'b1 || mem_din !== 8'h5A || mem_a !== 14'h3FFF) begin
      failures++;
      $display("FAIL wr_cycle: ack0=%b ce/oe/we=%b%b%b din=%h a=%h, required 1 010 5a 3fff", ack0, mem_ce_n, mem_oe_n, mem_we_n, mem_din, mem_a);
    end
    req0 = 1'b0;
    ref_mem[14'h3FFF] = 8'h5A;
    tick();
    checks++;
    if (mem_we_n !== 1'b1 || mem_ce_n !== 1'b1 || ack0 !== 1'b0) begin
      failures++;
      $display("FAIL wr_single: we_n=%b ce_n=%b ack0=%b, required 1 1 0", mem_we_n, mem_ce_n, ack0);
    end
    access(1'b0, 1'b0, 14'h3FFF, 8'h00);
    access(1'b0, 1'b1, 14'h0010, DW'($urandom));
    access(1'b0, 1'b0, 14'h0010, 8'h00);
  endtask

  task automatic test_alternate();
    logic [AW-1:0] cur [2];
    logic [AW-1:0] ga [8];
    pulse_reset();
    cur[0] = AW'($urandom);
    cur[1] = AW'($urandom);
    req0 = 1'b1; we0 = 1'b0; addr0 = cur[0];
    req1 = 1'b1; we1 = 1'b0; addr1 = cur[1];
    for (int c = 1; c <= 18; c++) begin
      bit gcyc, vcyc;
      int k, kv;
      bit ea0, ea1;
      tick();
      k = (c - 1) / 2;
      kv = (c - 3) / 2;
      gcyc = (c % 2 == 1) && k < 8;
      vcyc = (c % 2 == 1) && c >= 3 && kv < 8;
      ea0 = gcyc && (k % 2 == 0);
      ea1 = gcyc && (k % 2 == 1);
      checks++;
      if (ack0 !== ea0 || ack1 !== ea1 || mem_ce_n !== (c > 16)) begin
        failures++;
        $display("FAIL alt_grant c=%0d: ack0=%b ack1=%b ce_n=%b, required %b %b %b", c, ack0, ack1, mem_ce_n, ea0, ea1, c > 16);
      end
      checks++;
      if (vcyc ? (rvalid !== 1'b1 || rport !== 1'(kv % 2) || rdata !== ref_mem[ga[kv]]) : rvalid !== 1'b0) begin
        failures++;
        $display("FAIL alt_read c=%0d: rvalid=%b rport=%b rdata=%h, required %b %0d %h", c, rvalid, rport, rdata,
                 vcyc, kv % 2, vcyc ? ref_mem[ga[kv]] : 8'h00);
      end
      if (gcyc) begin
        ga[k] = cur[k % 2];
        cur[k % 2] = AW'($urandom);
        if (k % 2 == 0) begin addr0 = cur[0]; req0 = k < 6; end
        else begin addr1 = cur[1]; req1 = k < 6; end
      end
    end
  endtask

  task automatic test_reset_midread();
    bit same = 1'b1;
    req1 = 1'b1; we1 = 1'b0; addr1 = AW'($urandom);
    tick();
    checks++;
    if (ack1 !== 1'b1 || mem_oe_n !== 1'b0) begin
      failures++;
      $display("FAIL rst_rd_setup: ack1=%b oe_n=%b, required 1 0", ack1, mem_oe_n);
    end
    rst_n = 1'b0;
    req1 = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({mem_ce_n, mem_oe_n, mem_we_n} !== 3'b111 || ack0 !== 1'b0 || ack1 !== 1'b0 || rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rst_rd_abandon: ce/oe/we=%b%b%b ack0=%b ack1=%b rvalid=%b, required 111 0 0 0",
               mem_ce_n, mem_oe_n, mem_we_n, ack0, ack1, rvalid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (rvalid !== 1'b0 || ack1 !== 1'b0 || mem_ce_n !== 1'b1) begin
        failures++;
        $display("FAIL rst_rd_quiet +%0d: rvalid=%b ack1=%b ce_n=%b, required 0 0 1", i, rvalid, ack1, mem_ce_n);
      end
    end
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) same = 1'b0;
    checks++;
    if (!same) begin
      failures++;
      $display("FAIL rst_rd_memory: contents changed, required unchanged image");
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] pool [8];
    bit same = 1'b1;
    for (int i = 0; i < 8; i++) pool[i] = AW'($urandom);
    for (int n = 0; n < 40; n++)
      access(1'($urandom), 1'($urandom), pool[$urandom_range(0, 7)], DW'($urandom));
    repeat (3) tick();
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) same = 1'b0;
    checks++;
    if (!same) begin
      failures++;
      $display("FAIL random_memory: RAM image differs from reference");
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'($urandom);
    test_reset();
    sync_mem();
    test_read_latency();
    test_write_then_read();
    test_alternate();
    test_reset_midread();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
